// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Arbitrates a single RAM port between an instruction-fetch requester and a
// data requester. Data normally wins. A saturating starvation counter forces
// an instruction grant after STARVE_LIMIT consecutive data grants taken while
// a fetch was waiting. RAM ERROR and access timeouts abort the transaction
// and raise a sticky err flag; the requester simply re-arbitrates.

module mem_req_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        nRST,

  // Instruction fetch side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,

  // Data side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,

  // Processor status
  input  logic        halt,

  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,

  // Status
  output logic [1:0]  grant,
  output logic        err
);

  // Counter widths: the starvation counter must hold STARVE_LIMIT, the
  // timeout counter must be able to reach TIMEOUT_CYCLES.
  localparam int unsigned SW = (STARVE_LIMIT   < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TIMEOUT_AT = TW'(TIMEOUT_CYCLES);

  // Encoding doubles as the grant code driven to the outside.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_e;

  state_e          state_q,   state_d;
  logic [SW-1:0]   starve_q,  starve_d;
  logic [TW-1:0]   timeout_q, timeout_d;
  logic            err_q,     err_d;

  ramstate_e       ram_st;
  logic            inst_req;
  logic            data_req;
  logic            owner_req;
  logic            hit;

  assign ram_st   = ramstate_e'(ramstate);
  // halt only gates new instruction grants; it is not part of owner_req, so
  // a fetch already in flight is never aborted by it.
  assign inst_req = iREN & ~halt;
  assign data_req = dREN | dWEN;

  // State, starvation counter, timeout counter and sticky error flag.
  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      timeout_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  // Arbitration in IDLE, completion/abort handling in the ACC states.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    owner_req = 1'b0;
    hit       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (inst_req && (!data_req || (starve_q == STARVE_MAX))) begin
          state_d   = I_ACC;
          starve_d  = '0;
          timeout_d = '0;
        end else if (data_req) begin
          state_d   = D_ACC;
          timeout_d = '0;
          // Count data grants that overtook a waiting fetch; any data grant
          // with no fetch waiting breaks the streak.
          if (inst_req) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
        end
      end

      I_ACC, D_ACC: begin
        owner_req = (state_q == I_ACC) ? iREN : data_req;
        if (!owner_req) begin
          // Requester withdrew before completion: release the RAM quietly.
          state_d = IDLE;
        end else if (ram_st == RAM_ACCESS) begin
          hit     = 1'b1;
          state_d = IDLE;
        end else begin
          timeout_d = timeout_q + TW'(1);
          if (ram_st == RAM_ERROR) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (timeout_d == TIMEOUT_AT) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM strobes, address/data muxing and requester handshakes per owner.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;

    unique case (state_q)
      I_ACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = ~hit;
      end

      D_ACC: begin
        // A simultaneous read and write request is treated as a write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = ~hit;
      end

      default: begin
      end
    endcase
  end

  assign grant = state_q;
  assign err   = err_q;

endmodule
